// File: rtl/histo_eq_mapper.sv
// Histogram equalisation mapper: builds an 8-bit level LUT from the cumulative
// histogram during blanking and remaps live grey pixels through a ping-pong LUT.
module histo_eq_mapper #(
    parameter int CDF_W       = 20,
    parameter int SCALE_MUL   = 870,
    parameter int SCALE_SHIFT = 20,
    parameter int BINS        = 256
) (
    input  logic             iPclk,
    input  logic             iRST_N,
    input  logic             iFval,
    input  logic             iDval,
    input  logic [11:0]      iGrey,
    output logic [7:0]       oCdf_Addr,
    output logic             oCdf_Rd,
    input  logic [CDF_W-1:0] iCdf_Data,
    output logic [11:0]      oEq_Grey,
    output logic             oEq_Dval,
    output logic             oBusy,
    output logic             oLut_Valid
);

    localparam int PROD_W = CDF_W + 12;
    localparam logic [7:0] LAST_ADDR = 8'(BINS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t             state_reg;
    logic               fval_reg;
    logic               drain_reg;
    logic               bank_reg;
    logic               pending_reg;
    logic               rd_d1_reg;
    logic [7:0]         addr_d1_reg;
    logic [CDF_W-1:0]   cap_reg;
    logic               wr_en_reg;
    logic [7:0]         wr_addr_reg;
    logic [11:0]        s1_grey_reg;
    logic               s1_dval_reg;

    // Two banks of 256 levels; the bank bit is the address MSB.
    logic [7:0]         lut_mem [0:511];

    logic               fval_rise;
    logic               fval_fall;
    logic [PROD_W-1:0]  product;
    logic [PROD_W-1:0]  shifted;
    logic [7:0]         scaled;
    logic [7:0]         lut_word;

    assign fval_rise = iFval & ~fval_reg;
    assign fval_fall = ~iFval & fval_reg;
    assign product   = PROD_W'(cap_reg) * PROD_W'(SCALE_MUL);
    assign shifted   = product >> SCALE_SHIFT;
    assign scaled    = (shifted > PROD_W'(255)) ? 8'hFF : shifted[7:0];
    assign lut_word  = lut_mem[{bank_reg, s1_grey_reg[11:4]}];

    always_ff @(posedge iPclk or negedge iRST_N) begin
        if (!iRST_N) begin
            state_reg   <= IDLE;
            fval_reg    <= 1'b0;
            drain_reg   <= 1'b0;
            bank_reg    <= 1'b0;
            pending_reg <= 1'b0;
            rd_d1_reg   <= 1'b0;
            addr_d1_reg <= '0;
            cap_reg     <= '0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            oCdf_Addr   <= '0;
            oCdf_Rd     <= 1'b0;
            oBusy       <= 1'b0;
            oLut_Valid  <= 1'b0;
        end else begin
            fval_reg    <= iFval;
            rd_d1_reg   <= oCdf_Rd;
            addr_d1_reg <= oCdf_Addr;
            cap_reg     <= iCdf_Data;
            wr_en_reg   <= rd_d1_reg;
            wr_addr_reg <= addr_d1_reg;
            if (fval_rise && state_reg != IDLE) begin
                // Frame started before the build finished: drop it, keep the active bank.
                state_reg <= IDLE;
                oCdf_Rd   <= 1'b0;
                oBusy     <= 1'b0;
                rd_d1_reg <= 1'b0;
                wr_en_reg <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (fval_rise && pending_reg) begin
                            bank_reg    <= ~bank_reg;
                            pending_reg <= 1'b0;
                            oLut_Valid  <= 1'b1;
                        end else if (fval_fall) begin
                            state_reg <= LOAD;
                            oCdf_Addr <= '0;
                            oCdf_Rd   <= 1'b1;
                            oBusy     <= 1'b1;
                        end
                    end
                    LOAD: begin
                        if (oCdf_Addr == LAST_ADDR) begin
                            state_reg <= DRAIN;
                            oCdf_Rd   <= 1'b0;
                            drain_reg <= 1'b0;
                        end else begin
                            oCdf_Addr <= oCdf_Addr + 8'd1;
                        end
                    end
                    DRAIN: begin
                        if (drain_reg) begin
                            state_reg   <= IDLE;
                            oBusy       <= 1'b0;
                            pending_reg <= 1'b1;
                        end else begin
                            drain_reg <= 1'b1;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge iPclk) begin
        if (wr_en_reg)
            lut_mem[{~bank_reg, wr_addr_reg}] <= scaled;
    end

    always_ff @(posedge iPclk or negedge iRST_N) begin
        if (!iRST_N) begin
            s1_grey_reg <= '0;
            s1_dval_reg <= 1'b0;
            oEq_Grey    <= '0;
            oEq_Dval    <= 1'b0;
        end else begin
            s1_grey_reg <= iGrey;
            s1_dval_reg <= iDval;
            oEq_Dval    <= s1_dval_reg;
            if (!s1_dval_reg)
                oEq_Grey <= '0;
            else if (oLut_Valid)
                oEq_Grey <= {lut_word, lut_word[7:4]};
            else
                oEq_Grey <= s1_grey_reg;
        end
    end

endmodule

// File: tb/tb_histo_eq_mapper.sv
// Directed bench for histo_eq_mapper: builds, swaps, saturation, abort and
// pixel-path timing checked against hand-computed values.
module tb_histo_eq_mapper;

    logic        iPclk = 1'b0;
    logic        iRST_N = 1'b0;
    logic        iFval = 1'b0;
    logic        iDval = 1'b0;
    logic [11:0] iGrey = '0;
    logic [7:0]  oCdf_Addr;
    logic        oCdf_Rd;
    logic [19:0] iCdf_Data = '0;
    logic [11:0] oEq_Grey;
    logic        oEq_Dval;
    logic        oBusy;
    logic        oLut_Valid;

    int tests = 0;
    int fails = 0;
    bit sat_mode = 1'b0;

    histo_eq_mapper dut (
        .iPclk(iPclk), .iRST_N(iRST_N), .iFval(iFval), .iDval(iDval),
        .iGrey(iGrey), .oCdf_Addr(oCdf_Addr), .oCdf_Rd(oCdf_Rd),
        .iCdf_Data(iCdf_Data), .oEq_Grey(oEq_Grey), .oEq_Dval(oEq_Dval),
        .oBusy(oBusy), .oLut_Valid(oLut_Valid)
    );

    always #5 iPclk = ~iPclk;

    // Cumulative table: entry k = 1200*(k+1), or all-ones for saturation runs.
    always @(posedge iPclk)
        iCdf_Data <= sat_mode ? 20'hFFFFF : 20'(1200 * (int'(oCdf_Addr) + 1));

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge iPclk);
        #1;
    endtask

    task automatic pix(input string tag, input logic [11:0] g, input int exp);
        iGrey = g;
        iDval = 1'b1;
        tick();
        iDval = 1'b0;
        iGrey = '0;
        check({tag, "_lat1_dval"}, oEq_Dval, 0);
        tick();
        check({tag, "_dval"}, oEq_Dval, 1);
        check(tag, oEq_Grey, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rd_cnt, busy_cnt, addr_bad, exp_addr, n;
        logic [11:0] g_tab [4];
        logic [11:0] e_tab [4];
        g_tab = '{12'h7F0, 12'hFF0, 12'h100, 12'h7F5};
        e_tab = '{12'h7F7, 12'hFEF, 12'h101, 12'h7F7};

        repeat (3) tick();
        check("rst_busy", oBusy, 0);
        check("rst_rd", oCdf_Rd, 0);
        check("rst_addr", oCdf_Addr, 0);
        check("rst_lut_valid", oLut_Valid, 0);
        check("rst_eq_grey", oEq_Grey, 0);
        check("rst_eq_dval", oEq_Dval, 0);
        iRST_N = 1'b1;

        // Reset asserted in the middle of a build
        iFval = 1'b1;
        repeat (3) tick();
        iFval = 1'b0;
        repeat (20) tick();
        check("midload_busy", oBusy, 1);
        iRST_N = 1'b0;
        #1;
        check("midrst_busy", oBusy, 0);
        check("midrst_rd", oCdf_Rd, 0);
        check("midrst_lut_valid", oLut_Valid, 0);
        tick();
        iRST_N = 1'b1;
        tick();
        check("after_rst_busy", oBusy, 0);
        pix("passthru_A50", 12'hA50, 12'hA50);

        // Full build from the ramp table
        sat_mode = 1'b0;
        iFval = 1'b1;
        repeat (4) tick();
        iFval = 1'b0;
        rd_cnt = 0; busy_cnt = 0; addr_bad = 0; exp_addr = 0;
        repeat (300) begin
            tick();
            if (oBusy) busy_cnt++;
            if (oCdf_Rd) begin
                if (int'(oCdf_Addr) != exp_addr) addr_bad++;
                exp_addr++;
                rd_cnt++;
            end
        end
        check("build_rd_cycles", rd_cnt, 256);
        check("build_busy_cycles", busy_cnt, 258);
        check("build_addr_seq_errors", addr_bad, 0);
        check("build_no_swap_yet", oLut_Valid, 0);

        iFval = 1'b1;
        tick();
        check("swap_lut_valid", oLut_Valid, 1);
        pix("bin127", 12'h7F0, 12'h7F7);
        pix("bin255", 12'hFF0, 12'hFEF);
        pix("bin0", 12'h000, 12'h000);
        pix("bin16", 12'h100, 12'h101);

        // iDval toggling every cycle
        for (int i = 0; i < 10; i++) begin
            iGrey = g_tab[i % 4];
            iDval = (i % 2 == 0);
            tick();
            if (i >= 1) begin
                int j;
                j = i - 1;
                check($sformatf("toggle_dval_%0d", j), oEq_Dval, (j % 2 == 0) ? 1 : 0);
                check($sformatf("toggle_grey_%0d", j), oEq_Grey,
                      (j % 2 == 0) ? int'(e_tab[j % 4]) : 0);
            end
        end
        iDval = 1'b0;
        iGrey = '0;
        tick();

        // Abort a saturating build at cycle 100
        sat_mode = 1'b1;
        iFval = 1'b0;
        repeat (100) tick();
        check("abort_busy_before", oBusy, 1);
        iFval = 1'b1;
        tick();
        check("abort_busy", oBusy, 0);
        check("abort_rd", oCdf_Rd, 0);
        check("abort_lut_valid", oLut_Valid, 1);
        pix("abort_old_map", 12'h7F0, 12'h7F7);
        repeat (20) tick();
        pix("abort_old_map_late", 12'hFF0, 12'hFEF);

        // Saturating build completes and is swapped in
        iFval = 1'b0;
        tick();
        n = 0;
        while (n < 600) begin
            tick();
            n++;
            if (!oBusy) break;
        end
        check("sat_build_done", (n < 600) ? 1 : 0, 1);
        check("sat_build_len", n, 258);
        iFval = 1'b1;
        tick();
        pix("sat_bin0", 12'h000, 12'hFFF);
        pix("sat_bin127", 12'h7F0, 12'hFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
